// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner: FSM states, matrix size and
// the row-sample classifier used on every slot tick.
package keypad_pkg;

   localparam int unsigned KP_ROWS = 4;
   localparam int unsigned KP_COLS = 4;

   typedef enum logic [1:0] {
      KS_SCAN     = 2'd0,
      KS_DEBOUNCE = 2'd1,
      KS_HELD     = 2'd2,
      KS_RELEASE  = 2'd3
   } ks_state_e;

   typedef enum logic [1:0] {
      SC_NONE   = 2'd0,
      SC_SINGLE = 2'd1,
      SC_MULTI  = 2'd2
   } sample_class_e;

   typedef struct packed {
      sample_class_e cls;
      logic [1:0]    row;
   } sample_t;

   // Rows are active-low; row is only meaningful when cls is SC_SINGLE.
   function automatic sample_t classify_rows(input logic [KP_ROWS-1:0] rows_n);
      sample_t     s;
      int unsigned lows;
      s.cls = SC_NONE;
      s.row = 2'd0;
      lows  = 0;
      for (int r = 0; r < int'(KP_ROWS); r++) begin
         if (!rows_n[r]) begin
            lows++;
            s.row = 2'(r);
         end
      end
      if (lows == 1) begin
         s.cls = SC_SINGLE;
      end else if (lows > 1) begin
         s.cls = SC_MULTI;
      end
      return s;
   endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running slot counter: counts 0..DIV-1 and raises tick for one cycle on the
// last count. Shared with the display multiplexer.
module scan_tick #(
   parameter int unsigned DIV = 2500
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 2;

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == CW'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce and a one-cycle press pulse.
// Define KEYPAD_ROW_SYNC_EN to pass row_n through a 2-flop synchronizer first.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 2500,
   parameter int unsigned DEBOUNCE_CNT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [KP_ROWS-1:0] row_n,
   output logic [KP_COLS-1:0] col_n,
   output logic [3:0]         key_code,
   output logic               key_valid,
   output logic               pressed
);

   logic               tick;
   logic [KP_ROWS-1:0] rows_s;
   sample_t            samp;
   logic               hit;

   ks_state_e          state_q, state_d;
   logic [1:0]         col_idx_q, col_idx_d;
   logic [KP_COLS-1:0] col_n_q, col_n_d;
   logic [3:0]         cand_q, cand_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [3:0]         key_code_q, key_code_d;
   logic               key_valid_q, key_valid_d;
   logic               pressed_q, pressed_d;

   scan_tick #(
      .DIV (SCAN_DIV)
   ) u_scan_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

`ifdef KEYPAD_ROW_SYNC_EN
   logic [KP_ROWS-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= row_n;
         sync2_q <= sync1_q;
      end
   end

   assign rows_s = sync2_q;
`else
   assign rows_s = row_n;
`endif

   assign samp = classify_rows(rows_s);
   assign hit  = (samp.cls == SC_SINGLE) && ({samp.row, col_idx_q} == cand_q);

   always_comb begin
      state_d     = state_q;
      col_idx_d   = col_idx_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q;
      pressed_d   = 1'b0;

      if (tick) begin
         unique case (state_q)
            KS_SCAN: begin
               if (samp.cls == SC_SINGLE) begin
                  cand_d  = {samp.row, col_idx_q};
                  cnt_d   = 4'd0;
                  state_d = KS_DEBOUNCE;
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end
            KS_DEBOUNCE: begin
               if (hit) begin
                  if (cnt_q == 4'(DEBOUNCE_CNT - 1)) begin
                     state_d     = KS_HELD;
                     cnt_d       = 4'd0;
                     key_code_d  = cand_q;
                     key_valid_d = 1'b1;
                     pressed_d   = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else begin
                  // Column stays put here; advance resumes on the next tick in SCAN.
                  cnt_d   = 4'd0;
                  state_d = KS_SCAN;
               end
            end
            KS_HELD: begin
               if (samp.cls == SC_NONE) begin
                  cnt_d   = 4'd0;
                  state_d = KS_RELEASE;
               end
            end
            KS_RELEASE: begin
               if (samp.cls == SC_NONE) begin
                  if (cnt_q == 4'(DEBOUNCE_CNT - 1)) begin
                     cnt_d       = 4'd0;
                     key_valid_d = 1'b0;
                     state_d     = KS_SCAN;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else begin
                  cnt_d = 4'd0;
               end
            end
         endcase
      end

      col_n_d = ~(4'b0001 << col_idx_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= KS_SCAN;
         col_idx_q   <= 2'd0;
         col_n_q     <= 4'b1110;
         cand_q      <= 4'd0;
         cnt_q       <= 4'd0;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         pressed_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         col_n_q     <= col_n_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         pressed_q   <= pressed_d;
      end
   end

   assign col_n     = col_n_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign pressed   = pressed_q;

endmodule
